// File: rtl/seg_scan_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_capture_if
// Brief    : Multiplexed display bus (anode/nibble) plus frame readback signals.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_capture_if;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic [13:0] frame_value;
    logic        frame_valid;
    logic        seq_err;
    logic        an_err;
    logic        rng_err;

    // Display-driver side: drives the scan, observes the readback.
    modport master (
        output an,
        output digit,
        input  frame_value,
        input  frame_valid,
        input  seq_err,
        input  an_err,
        input  rng_err
    );

    // Capture side.
    modport slave (
        input  an,
        input  digit,
        output frame_value,
        output frame_valid,
        output seq_err,
        output an_err,
        output rng_err
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_capture
// Brief    : Rebuilds the 14-bit displayed value from a 4-digit scan bus.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_capture #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    seg_scan_capture_if.slave bus
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_EXP1 = 2'd1,
        ST_EXP2 = 2'd2,
        ST_EXP3 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_SETTLE    = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] c_SETTLE_M1 = CNT_W'(SETTLE - 1);
    localparam logic [3:0]       c_BLANK     = 4'b1111;

    function automatic logic is_digit(input logic [3:0] a);
        is_digit = (a == 4'b1110) || (a == 4'b1101) ||
                   (a == 4'b1011) || (a == 4'b0111);
    endfunction

    function automatic logic [1:0] digit_index(input logic [3:0] a);
        case (a)
            4'b1101: digit_index = 2'd1;
            4'b1011: digit_index = 2'd2;
            4'b0111: digit_index = 2'd3;
            default: digit_index = 2'd0;
        endcase
    endfunction

    logic [3:0]       an_q, an_prev_q, digit_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [3:0]       d0_q, d1_q, d2_q;
    logic [3:0]       d0_d, d1_d, d2_d;
    logic [13:0]      frame_value_q, frame_value_d;
    logic             frame_valid_q, frame_valid_d;
    logic             seq_err_q, seq_err_d;
    logic             an_err_q, an_err_d;
    logic             rng_err_q, rng_err_d;

    logic             w_new_pat;
    logic             w_cur_dig;
    logic [1:0]       w_cur_idx;
    logic             w_an_inv;
    logic [CNT_W-1:0] w_cnt_cur;
    logic             w_capture;
    logic             w_early;
    state_t           w_eval_state;

    assign w_new_pat = (an_q != an_prev_q);
    assign w_cur_dig = is_digit(an_q);
    assign w_cur_idx = digit_index(an_q);
    assign w_an_inv  = !w_cur_dig && (an_q != c_BLANK);

    // Counter view for this cycle: a fresh dwell starts from zero.
    assign w_cnt_cur = w_new_pat ? '0 : cnt_q;
    assign cnt_d     = (w_cnt_cur < c_SETTLE) ? w_cnt_cur + CNT_W'(1) : w_cnt_cur;
    assign w_capture = w_cur_dig && (w_cnt_cur == c_SETTLE_M1);

    // cnt_q still holds the (saturated) length of the dwell that just ended.
    assign w_early   = w_new_pat && is_digit(an_prev_q) && (cnt_q < c_SETTLE);

    always_comb begin
        state_d       = state_q;
        w_eval_state  = state_q;
        d0_d          = d0_q;
        d1_d          = d1_q;
        d2_d          = d2_q;
        frame_value_d = frame_value_q;
        frame_valid_d = 1'b0;
        seq_err_d     = 1'b0;
        an_err_d      = 1'b0;
        rng_err_d     = 1'b0;

        if (w_new_pat && w_an_inv) begin
            an_err_d = 1'b1;
            state_d  = ST_HUNT;
        end else begin
            if (w_early) begin
                seq_err_d    = 1'b1;
                w_eval_state = ST_HUNT;
                state_d      = ST_HUNT;
            end
            if (w_capture) begin
                if (w_eval_state == ST_HUNT) begin
                    if (w_cur_idx == 2'd0) begin
                        d0_d    = digit_q;
                        state_d = ST_EXP1;
                    end
                end else if (state_t'(w_cur_idx) == w_eval_state) begin
                    case (w_eval_state)
                        ST_EXP1: begin
                            d1_d    = digit_q;
                            state_d = ST_EXP2;
                        end
                        ST_EXP2: begin
                            d2_d    = digit_q;
                            state_d = ST_EXP3;
                        end
                        default: begin
                            if (digit_q[3:2] == 2'b00) begin
                                frame_value_d = {digit_q[1:0], d2_q, d1_q, d0_q};
                                frame_valid_d = 1'b1;
                            end else begin
                                rng_err_d = 1'b1;
                            end
                            state_d = ST_HUNT;
                        end
                    endcase
                end else begin
                    // Out-of-order digit; a digit0 restarts the frame.
                    seq_err_d = 1'b1;
                    if (w_cur_idx == 2'd0) begin
                        d0_d    = digit_q;
                        state_d = ST_EXP1;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q          <= c_BLANK;
            an_prev_q     <= c_BLANK;
            digit_q       <= 4'h0;
            cnt_q         <= '0;
            state_q       <= ST_HUNT;
            d0_q          <= 4'h0;
            d1_q          <= 4'h0;
            d2_q          <= 4'h0;
            frame_value_q <= 14'h0;
            frame_valid_q <= 1'b0;
            seq_err_q     <= 1'b0;
            an_err_q      <= 1'b0;
            rng_err_q     <= 1'b0;
        end else begin
            an_q          <= bus.an;
            an_prev_q     <= an_q;
            digit_q       <= bus.digit;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            d0_q          <= d0_d;
            d1_q          <= d1_d;
            d2_q          <= d2_d;
            frame_value_q <= frame_value_d;
            frame_valid_q <= frame_valid_d;
            seq_err_q     <= seq_err_d;
            an_err_q      <= an_err_d;
            rng_err_q     <= rng_err_d;
        end
    end

    assign bus.frame_value = frame_value_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.an_err      = an_err_q;
    assign bus.rng_err     = rng_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_capture
// Brief    : Directed + random scans into SETTLE=1 and SETTLE=3 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_capture;

    typedef struct packed {
        logic [13:0] value;
        logic        fv;
        logic        seq;
        logic        aerr;
        logic        rng;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] an_drv = 4'hF;
    logic [3:0] digit_drv = 4'h0;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    seg_scan_capture_if bus1();
    seg_scan_capture_if bus3();

    assign bus1.an    = an_drv;
    assign bus1.digit = digit_drv;
    assign bus3.an    = an_drv;
    assign bus3.digit = digit_drv;

    seg_scan_capture #(.SETTLE(1), .CNT_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    seg_scan_capture #(.SETTLE(3), .CNT_W(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // Reference model: dwell lengths and a partial-frame digit list.
    int          settle_of [2] = '{1, 3};
    logic [3:0]  m_last [2];
    int          m_run  [2];
    logic [3:0]  m_part [2][3];
    int          m_len  [2];
    logic [13:0] m_val  [2];
    res_t        latest [2];
    res_t        prev   [2];
    int          cnt_fv [2], cnt_seq [2], cnt_an [2], cnt_rng [2];

    function automatic int dig_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] pat(input int i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return ~one;
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_last[m] = 4'hF;
            m_run[m]  = 0;
            m_len[m]  = 0;
            m_val[m]  = 14'h0;
            latest[m] = '0;
            prev[m]   = '0;
        end
    endtask

    task automatic clear_counts();
        for (int m = 0; m < 2; m++) begin
            cnt_fv[m] = 0; cnt_seq[m] = 0; cnt_an[m] = 0; cnt_rng[m] = 0;
        end
    endtask

    task automatic model_step(input int m, input logic [3:0] a, input logic [3:0] d, output res_t r);
        int idx;
        r   = '0;
        idx = dig_idx(a);
        if (a != m_last[m]) begin
            if (idx < 0 && a != 4'hF) begin
                r.aerr   = 1'b1;
                m_len[m] = 0;
            end else if (dig_idx(m_last[m]) >= 0 && m_run[m] < settle_of[m]) begin
                r.seq    = 1'b1;
                m_len[m] = 0;
            end
            m_run[m] = 1;
        end else if (m_run[m] < 100) begin
            m_run[m]++;
        end
        m_last[m] = a;
        if (idx >= 0 && m_run[m] == settle_of[m]) begin
            if (m_len[m] == 0) begin
                if (idx == 0) begin m_part[m][0] = d; m_len[m] = 1; end
            end else if (idx == m_len[m]) begin
                if (idx == 3) begin
                    if (d[3:2] == 2'b00) begin
                        m_val[m] = {d[1:0], m_part[m][2], m_part[m][1], m_part[m][0]};
                        r.fv = 1'b1;
                    end else begin
                        r.rng = 1'b1;
                    end
                    m_len[m] = 0;
                end else begin
                    m_part[m][idx] = d;
                    m_len[m] = idx + 1;
                end
            end else begin
                r.seq    = 1'b1;
                m_len[m] = 0;
                if (idx == 0) begin m_part[m][0] = d; m_len[m] = 1; end
            end
        end
        r.value = m_val[m];
    endtask

    task automatic check_one(input string nm, input res_t e, input logic [13:0] v,
                             input logic fv, input logic se, input logic ae, input logic re);
        chk({nm, "_frame_value"}, v, e.value);
        chk({nm, "_frame_valid"}, {13'h0, fv}, {13'h0, e.fv});
        chk({nm, "_seq_err"},     {13'h0, se}, {13'h0, e.seq});
        chk({nm, "_an_err"},      {13'h0, ae}, {13'h0, e.aerr});
        chk({nm, "_rng_err"},     {13'h0, re}, {13'h0, e.rng});
    endtask

    // One cycle: check outputs due now, drive the next input, advance the model.
    task automatic step(input logic [3:0] a, input logic [3:0] d);
        res_t r;
        @(negedge clk);
        check_one("s1", prev[0], bus1.frame_value, bus1.frame_valid, bus1.seq_err, bus1.an_err, bus1.rng_err);
        check_one("s3", prev[1], bus3.frame_value, bus3.frame_valid, bus3.seq_err, bus3.an_err, bus3.rng_err);
        cnt_fv[0] += int'(bus1.frame_valid); cnt_seq[0] += int'(bus1.seq_err);
        cnt_an[0] += int'(bus1.an_err);      cnt_rng[0] += int'(bus1.rng_err);
        cnt_fv[1] += int'(bus3.frame_valid); cnt_seq[1] += int'(bus3.seq_err);
        cnt_an[1] += int'(bus3.an_err);      cnt_rng[1] += int'(bus3.rng_err);
        an_drv    = a;
        digit_drv = d;
        for (int m = 0; m < 2; m++) begin
            model_step(m, a, d, r);
            prev[m]   = latest[m];
            latest[m] = r;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        an_drv    = 4'hF;
        digit_drv = 4'h0;
        #1;
        chk("rst_s1_value", bus1.frame_value, 14'h0);
        chk("rst_s3_value", bus3.frame_value, 14'h0);
        chk("rst_s1_flags", {10'h0, bus1.frame_valid, bus1.seq_err, bus1.an_err, bus1.rng_err}, 14'h0);
        chk("rst_s3_flags", {10'h0, bus3.frame_valid, bus3.seq_err, bus3.an_err, bus3.rng_err}, 14'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic dwell(input int i, input logic [3:0] d, input int n);
        for (int k = 0; k < n; k++) step(pat(i), d);
    endtask

    task automatic scan(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                        input logic [3:0] d3, input int n, input int gap);
        logic [3:0] dv [4];
        dv = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            dwell(i, dv[i], n);
            for (int g = 0; g < gap; g++) step(4'hF, 4'h0);
        end
    endtask

    task automatic flush();
        for (int k = 0; k < 4; k++) step(4'hF, 4'h0);
    endtask

    task automatic expect_counts(input string nm, input int m, input int fv, input int se,
                                 input int ae, input int re);
        chk_int({nm, "_fv"},  cnt_fv[m],  fv);
        chk_int({nm, "_seq"}, cnt_seq[m], se);
        chk_int({nm, "_an"},  cnt_an[m],  ae);
        chk_int({nm, "_rng"}, cnt_rng[m], re);
        cnt_fv[m] = 0; cnt_seq[m] = 0; cnt_an[m] = 0; cnt_rng[m] = 0;
    endtask

    initial begin
        logic [3:0] bad [4];
        int         nxt;
        bad = '{4'b0000, 4'b1010, 4'b0011, 4'b1100};
        model_reset();
        clear_counts();
        do_reset();

        // Clean scan of 0x2A5C
        scan(4'hC, 4'h5, 4'hA, 4'h2, 4, 0);
        flush();
        chk("clean_s1", bus1.frame_value, 14'h2A5C);
        chk("clean_s3", bus3.frame_value, 14'h2A5C);
        expect_counts("clean_s1", 0, 1, 0, 0, 0);
        expect_counts("clean_s3", 1, 1, 0, 0, 0);

        // Same scan with blanking between digits
        scan(4'hC, 4'h5, 4'hA, 4'h2, 4, 2);
        flush();
        chk("blank_s1", bus1.frame_value, 14'h2A5C);
        expect_counts("blank_s1", 0, 1, 0, 0, 0);
        expect_counts("blank_s3", 1, 1, 0, 0, 0);

        // Order 0,1,3 then a full scan of 0x1234
        dwell(0, 4'h1, 4); dwell(1, 4'h2, 4); dwell(3, 4'h0, 4);
        flush();
        expect_counts("order_s1", 0, 0, 1, 0, 0);
        scan(4'h4, 4'h3, 4'h2, 4'h1, 4, 0);
        flush();
        chk("after_order_s1", bus1.frame_value, 14'h1234);
        chk("after_order_s3", bus3.frame_value, 14'h1234);
        clear_counts();

        // Invalid anode pattern held for 3 cycles mid-frame
        dwell(0, 4'h7, 4); dwell(1, 4'h7, 4);
        for (int k = 0; k < 3; k++) step(4'b1010, 4'h7);
        flush();
        chk("an_keep_s1", bus1.frame_value, 14'h1234);
        expect_counts("an_s1", 0, 0, 0, 1, 0);
        expect_counts("an_s3", 1, 0, 0, 1, 0);

        // Out-of-range digit3
        scan(4'h1, 4'h2, 4'h3, 4'hC, 4, 0);
        flush();
        chk("rng_keep_s1", bus1.frame_value, 14'h1234);
        expect_counts("rng_s1", 0, 0, 0, 0, 1);
        expect_counts("rng_s3", 1, 0, 0, 0, 1);

        // Short digit1 dwell: too short only for SETTLE=3
        dwell(0, 4'h0, 4); dwell(1, 4'h9, 2); dwell(2, 4'h8, 4); dwell(3, 4'h3, 4);
        flush();
        chk("short_s1", bus1.frame_value, 14'h3890);
        chk("short_s3", bus3.frame_value, 14'h1234);
        expect_counts("short_s1", 0, 1, 0, 0, 0);
        expect_counts("short_s3", 1, 0, 1, 0, 0);

        // Reset mid-frame, then a clean frame
        dwell(0, 4'h5, 4); dwell(1, 4'h6, 2);
        do_reset();
        scan(4'hC, 4'h5, 4'hA, 4'h2, 4, 1);
        flush();
        chk("post_rst_s1", bus1.frame_value, 14'h2A5C);
        chk("post_rst_s3", bus3.frame_value, 14'h2A5C);

        // Randomised scans checked cycle by cycle against the model
        nxt = 0;
        for (int t = 0; t < 400; t++) begin
            int         sel;
            int         len;
            logic [3:0] dg;
            sel = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 5));
            dg  = 4'($urandom_range(0, 15));
            if (sel <= 6) begin
                dwell(nxt, dg, len);
                nxt = (nxt + 1) % 4;
            end else if (sel == 7) begin
                dwell(int'($urandom_range(0, 3)), dg, len);
            end else if (sel == 8) begin
                for (int k = 0; k < len; k++) step(4'hF, dg);
            end else begin
                for (int k = 0; k < len; k++) step(bad[$urandom_range(0, 3)], dg);
            end
        end
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the 7-segment digit multiplexer.
- Watches the time-multiplexed anode-select and digit-nibble bus and rebuilds the 14-bit value being displayed.
- Emits one valid pulse per complete, in-order scan frame and flags malformed scans.
- Sits beside the display driver as a readback/self-check path; it also feeds the scoreboard logic that compares the displayed score against the internal score.

Parameters:
- SETTLE, 1, clock cycles a new anode pattern must hold stable before its nibble is captured (1..15).
- CNT_W, 4, width of the settle counter; must hold SETTLE.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- an  input  4  anode select, active-low one-hot (1110=digit0, 1101=digit1, 1011=digit2, 0111=digit3, 1111=blank).
- digit  input  4  nibble currently driven for the selected anode.
- frame_value  output  14  last complete frame: {d3[1:0],d2,d1,d0}.
- frame_valid  output  1  one-cycle pulse when frame_value updates.
- seq_err  output  1  one-cycle pulse: digit out of order, or anode changed before settling.
- an_err  output  1  one-cycle pulse: anode pattern not one-hot-low and not blank.
- rng_err  output  1  one-cycle pulse: digit3 nibble has bits [3:2] nonzero.

Behaviour:
- Reset (async, rst_n=0):
  - frame_value=0; frame_valid, seq_err, an_err and rng_err all 0.
  - FSM to HUNT; capture slots cleared; settle counter 0.
  - The input register is cleared to an=1111, digit=0.
- Input stage:
  - an and digit are registered once (an_q, digit_q); all decisions use the registered copies.
  - "New pattern" means an_q differs from its previous-cycle value.
- Settle counter:
  - Cleared on a new pattern; counts up while an_q is unchanged, saturating at SETTLE.
  - A nibble is captured exactly once per anode dwell: on the cycle the counter reaches SETTLE. The capture uses digit_q from that cycle.
- Blank (1111): ignored. It is legal between digits, does not advance the FSM, and raises no error.
- Invalid pattern (not one-hot-low, not 1111):
  - Detected on the new-pattern cycle.
  - an_err pulses and the FSM goes to HUNT.
  - A repeated identical invalid pattern does not re-pulse.
- A valid non-blank pattern that changes before the settle count is reached:
  - seq_err pulses on the change cycle and the FSM goes to HUNT.
  - The new pattern is then evaluated from HUNT.
- FSM states:
  - HUNT: waits for digit0 to settle; captures d0; moves to EXP1. Other settled digits are discarded silently.
  - EXP1: a settled digit1 captures d1 and moves to EXP2. A settled digit other than 1 is handled as below.
  - EXP2: the same rule for digit2; on success moves to EXP3.
  - EXP3: the same rule for digit3; on success captures d3 and completes the frame.
  - Wrong digit in EXP1..EXP3: seq_err pulses. If that digit is digit0, it is captured as the start of a new frame and the FSM moves to EXP1; otherwise the FSM goes to HUNT.
  - A re-settle of the same digit is not possible, since capture happens once per dwell.
- Frame completion (EXP3 capture):
  - If d3[3:2]==0: frame_value <= {d3[1:0],d2,d1,d0} and frame_valid pulses in the same cycle.
  - Otherwise: rng_err pulses and frame_value is unchanged.
  - In both cases the FSM moves to HUNT.
  - Back-to-back frames are supported: digit0 of the next frame is captured from HUNT.
- Latency: with digit3 first present on the inputs before edge E, frame_valid is high in the cycle after edge E+SETTLE (input register plus SETTLE counting cycles).
- Simultaneous events: at most one error pulse per cycle. Priority is an_err > seq_err > rng_err. frame_valid never coincides with any error.
- frame_value holds between frames.
- Reset mid-frame discards any partial capture with no pulses.

Test Plan:
- Reset then a clean scan of 0x2A5C (digits C,5,A,2 with 2-bit digit3=2), each dwell 4 cycles, SETTLE=1 -> one frame_valid, frame_value=14'h2A5C, no errors.
- Same scan with 1111 blanking cycles between digits -> identical result, no errors.
- Order 0,1,3 -> seq_err pulses on the digit3 settle cycle, FSM returns to HUNT. A following full scan of 0x1234 -> frame_valid with 14'h1234.
- an=1010 for 3 cycles mid-frame -> exactly one an_err pulse, no frame_valid. The previous frame_value is retained.
- digit3 nibble=4'hC -> rng_err pulse, frame_value unchanged.
- SETTLE=3 with a digit1 dwell of 2 cycles -> seq_err pulse. Separately, rst_n low mid-frame -> all outputs 0 immediately, and the next clean frame is captured normally.
